voting_machine_param: RTL and testbench

Parametrised successor to the five-candidate voting machine: N candidates, configurable counter width and password, one vote per successful authentication, saturating tallies, and a sequential winner scan with tie detection. It sits between the ballot-unit button and keypad inputs and the result display driver. `winner_idx` feeds the seven-segment encoder; `vote_counts` feeds the audit readout.

---
 rtl/voting_machine_param.sv | 247 ++++++++++++++++++++++++
 tb/tb_voting_machine_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voting_machine_param.sv
// voting_machine_param
// N-candidate ballot controller. Each correct password buys exactly one vote.
// Tallies saturate at their maximum value. When voting closes, a sequential
// scan picks the winner (the lowest index wins a tie) and flags shared maxima.
// Optional feature macro: VOTE_LOCKOUT_EN. When it is defined, MAX_FAIL
// consecutive wrong passwords lock the machine until admin_clear.
module voting_machine_param #(
    parameter int NUM_CAND = 5,
    parameter int CNT_W    = 8,
    parameter int PW_W     = 4,
    parameter logic [PW_W-1:0] PASSWORD = PW_W'(4'b1010),
    parameter int MAX_FAIL = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          auth,
    input  logic [PW_W-1:0]               password_in,
    input  logic [NUM_CAND-1:0]           vote,
    input  logic                          end_voting,
    input  logic                          admin_clear,
    output logic [NUM_CAND*CNT_W-1:0]     vote_counts,
    output logic                          auth_ok,
    output logic                          auth_fail,
    output logic                          vote_ack,
    output logic                          vote_err,
    output logic                          locked,
    output logic [$clog2(NUM_CAND)-1:0]   winner_idx,
    output logic                          winner_valid,
    output logic                          tie
);

    localparam int IDX_W  = $clog2(NUM_CAND);
    localparam int SCAN_W = $clog2(NUM_CAND + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SCAN_W-1:0]   SCAN_ONE  = {{(SCAN_W-1){1'b0}}, 1'b1};
    localparam logic [SCAN_W-1:0]   SCAN_LAST = SCAN_W'(NUM_CAND);
    localparam logic [FAIL_W-1:0]   FAIL_ONE  = {{(FAIL_W-1){1'b0}}, 1'b1};
    localparam logic [FAIL_W-1:0]   FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [NUM_CAND-1:0] VOTE_ONE  = {{(NUM_CAND-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_AUTH_WAIT = 3'd1,
        S_READY     = 3'd2,
        S_LOCKED    = 3'd3,
        S_SCAN      = 3'd4,
        S_RESULT    = 3'd5
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r [NUM_CAND];
    logic [FAIL_W-1:0]  fail_r;
    logic [SCAN_W-1:0]  scan_idx_r;
    logic [CNT_W-1:0]   max_r;
    logic [IDX_W-1:0]   best_r;
    logic               tie_scan_r;

    logic               auth_ok_r;
    logic               auth_fail_r;
    logic               vote_ack_r;
    logic               vote_err_r;
    logic               locked_r;
    logic [IDX_W-1:0]   winner_idx_r;
    logic               winner_valid_r;
    logic               tie_r;

    logic               vote_hot_s;
    logic               vote_any_s;
    logic               pw_match_s;
    logic [IDX_W-1:0]   scan_sel_s;
    logic [CNT_W-1:0]   scan_cnt_s;
    logic [FAIL_W-1:0]  fail_inc_s;

    // True when exactly one ballot bit is set.
    function automatic logic is_one_hot(input logic [NUM_CAND-1:0] v);
        return (v != {NUM_CAND{1'b0}}) && ((v & (v - VOTE_ONE)) == {NUM_CAND{1'b0}});
    endfunction

    // Decode the ballot, qualify the password and select the tally under scan.
    always_comb begin
        vote_hot_s = is_one_hot(vote);
        vote_any_s = (vote != {NUM_CAND{1'b0}});
        pw_match_s = (password_in == PASSWORD);
        if (scan_idx_r < SCAN_LAST) begin
            scan_sel_s = scan_idx_r[IDX_W-1:0];
        end else begin
            scan_sel_s = {IDX_W{1'b0}};
        end
        scan_cnt_s = cnt_r[scan_sel_s];
        if (fail_r == FAIL_MAX) begin
            fail_inc_s = fail_r;
        end else begin
            fail_inc_s = fail_r + FAIL_ONE;
        end
    end

    // Main controller: session FSM, tallies, winner scan and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            fail_r         <= {FAIL_W{1'b0}};
            scan_idx_r     <= {SCAN_W{1'b0}};
            max_r          <= {CNT_W{1'b0}};
            best_r         <= {IDX_W{1'b0}};
            tie_scan_r     <= 1'b0;
            auth_ok_r      <= 1'b0;
            auth_fail_r    <= 1'b0;
            vote_ack_r     <= 1'b0;
            vote_err_r     <= 1'b0;
            locked_r       <= 1'b0;
            winner_idx_r   <= {IDX_W{1'b0}};
            winner_valid_r <= 1'b0;
            tie_r          <= 1'b0;
        end else begin
            auth_ok_r   <= 1'b0;
            auth_fail_r <= 1'b0;
            vote_ack_r  <= 1'b0;
            vote_err_r  <= 1'b0;
            case (state_r)
                S_IDLE, S_RESULT: begin
                    if (start) begin
                        state_r        <= S_AUTH_WAIT;
                        for (int i = 0; i < NUM_CAND; i++) begin
                            cnt_r[i] <= {CNT_W{1'b0}};
                        end
                        fail_r         <= {FAIL_W{1'b0}};
                        winner_valid_r <= 1'b0;
                        winner_idx_r   <= {IDX_W{1'b0}};
                        tie_r          <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_AUTH_WAIT: begin
                    if (end_voting) begin
                        state_r    <= S_SCAN;
                        scan_idx_r <= {SCAN_W{1'b0}};
                        max_r      <= {CNT_W{1'b0}};
                        best_r     <= {IDX_W{1'b0}};
                        tie_scan_r <= 1'b0;
                    end else if (auth) begin
                        if (pw_match_s) begin
                            auth_ok_r <= 1'b1;
                            fail_r    <= {FAIL_W{1'b0}};
                            state_r   <= S_READY;
                        end else begin
                            auth_fail_r <= 1'b1;
                            fail_r      <= fail_inc_s;
`ifdef VOTE_LOCKOUT_EN
                            if (fail_inc_s == FAIL_MAX) begin
                                state_r  <= S_LOCKED;
                                locked_r <= 1'b1;
                            end else begin
                                state_r <= S_AUTH_WAIT;
                            end
`else
                            state_r <= S_AUTH_WAIT;
`endif
                        end
                    end else begin
                        state_r <= S_AUTH_WAIT;
                    end
                end
                S_READY: begin
                    if (end_voting) begin
                        // Any unused authenticated vote is simply dropped here.
                        state_r    <= S_SCAN;
                        scan_idx_r <= {SCAN_W{1'b0}};
                        max_r      <= {CNT_W{1'b0}};
                        best_r     <= {IDX_W{1'b0}};
                        tie_scan_r <= 1'b0;
                    end else if (vote_hot_s) begin
                        for (int i = 0; i < NUM_CAND; i++) begin
                            if (vote[i] && (cnt_r[i] != CNT_MAX)) begin
                                cnt_r[i] <= cnt_r[i] + CNT_ONE;
                            end else begin
                                cnt_r[i] <= cnt_r[i];
                            end
                        end
                        vote_ack_r <= 1'b1;
                        state_r    <= S_AUTH_WAIT;
                    end else if (vote_any_s) begin
                        vote_err_r <= 1'b1;
                        state_r    <= S_READY;
                    end else begin
                        state_r <= S_READY;
                    end
                end
                S_LOCKED: begin
                    // Only reachable with lockout enabled; admin_clear is the sole exit.
                    if (admin_clear) begin
                        state_r  <= S_AUTH_WAIT;
                        fail_r   <= {FAIL_W{1'b0}};
                        locked_r <= 1'b0;
                    end else begin
                        state_r <= S_LOCKED;
                    end
                end
                S_SCAN: begin
                    if (scan_idx_r == SCAN_LAST) begin
                        // Extra cycle after the last compare commits the result.
                        winner_idx_r   <= best_r;
                        tie_r          <= tie_scan_r;
                        winner_valid_r <= 1'b1;
                        state_r        <= S_RESULT;
                    end else begin
                        if ((scan_idx_r == {SCAN_W{1'b0}}) || (scan_cnt_s > max_r)) begin
                            max_r      <= scan_cnt_s;
                            best_r     <= scan_sel_s;
                            tie_scan_r <= 1'b0;
                        end else if (scan_cnt_s == max_r) begin
                            tie_scan_r <= 1'b1;
                        end else begin
                            tie_scan_r <= tie_scan_r;
                        end
                        scan_idx_r <= scan_idx_r + SCAN_ONE;
                        state_r    <= S_SCAN;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign auth_ok      = auth_ok_r;
    assign auth_fail    = auth_fail_r;
    assign vote_ack     = vote_ack_r;
    assign vote_err     = vote_err_r;
    assign locked       = locked_r;
    assign winner_idx   = winner_idx_r;
    assign winner_valid = winner_valid_r;
    assign tie          = tie_r;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_pack
        assign vote_counts[g*CNT_W +: CNT_W] = cnt_r[g];
    end

endmodule

// File: tb/tb_voting_machine_param.sv
// Self-checking bench for voting_machine_param: a table of directed single-cycle
// vectors plus hand-written sequences for saturation, held auth/lockout and reset.
module tb_voting_machine_param;

    logic        clk;
    logic        reset;
    logic        start;
    logic        auth;
    logic [3:0]  password_in;
    logic [4:0]  vote;
    logic        end_voting;
    logic        admin_clear;

    logic [39:0] vote_counts;
    logic        auth_ok, auth_fail, vote_ack, vote_err, locked;
    logic [2:0]  winner_idx;
    logic        winner_valid, tie;

    logic [9:0]  s_vote_counts;
    logic        s_auth_ok, s_auth_fail, s_vote_ack, s_vote_err, s_locked;
    logic [2:0]  s_winner_idx;
    logic        s_winner_valid, s_tie;

    int checks = 0;
    int errors = 0;

    voting_machine_param dut (
        .clk(clk), .reset(reset), .start(start), .auth(auth),
        .password_in(password_in), .vote(vote), .end_voting(end_voting),
        .admin_clear(admin_clear), .vote_counts(vote_counts),
        .auth_ok(auth_ok), .auth_fail(auth_fail), .vote_ack(vote_ack),
        .vote_err(vote_err), .locked(locked), .winner_idx(winner_idx),
        .winner_valid(winner_valid), .tie(tie)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    voting_machine_param #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .auth(auth),
        .password_in(password_in), .vote(vote), .end_voting(end_voting),
        .admin_clear(admin_clear), .vote_counts(s_vote_counts),
        .auth_ok(s_auth_ok), .auth_fail(s_auth_fail), .vote_ack(s_vote_ack),
        .vote_err(s_vote_err), .locked(s_locked), .winner_idx(s_winner_idx),
        .winner_valid(s_winner_valid), .tie(s_tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {auth_ok, auth_fail, vote_ack, vote_err, locked, winner_valid, tie}
    localparam logic [6:0] F_NO   = 7'b0000000;
    localparam logic [6:0] F_OK   = 7'b1000000;
    localparam logic [6:0] F_FAIL = 7'b0100000;
    localparam logic [6:0] F_ACK  = 7'b0010000;
    localparam logic [6:0] F_ERR  = 7'b0001000;
    localparam logic [6:0] F_WV   = 7'b0000010;
    localparam logic [6:0] F_TIE  = 7'b0000001;
    localparam logic [3:0] PW_OK  = 4'b1010;

    typedef struct {
        logic        st;
        logic        au;
        logic [3:0]  pw;
        logic [4:0]  vt;
        logic        ev;
        logic [6:0]  flags;
        logic [2:0]  widx;
        logic [39:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic au, input logic [3:0] pw,
                                input logic [4:0] vt, input logic ev, input logic [6:0] flags,
                                input logic [2:0] widx, input logic [39:0] cnt);
        vec_t v;
        v.st = st; v.au = au; v.pw = pw; v.vt = vt; v.ev = ev;
        v.flags = flags; v.widx = widx; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic st, input logic au, input logic [3:0] pw,
                         input logic [4:0] vt, input logic ev, input logic ac);
        start = st; auth = au; password_in = pw; vote = vt;
        end_voting = ev; admin_clear = ac;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Push n idle cycles expecting no activity while the scan runs.
    task automatic push_idle(input int n, input logic [39:0] cnt);
        for (int i = 0; i < n; i++) vecs.push_back(mk(1'b0, 1'b0, 4'h0, 5'b00000, 1'b0, F_NO, 3'd0, cnt));
    endtask

    initial begin
        logic [49:0] got_v;
        logic [49:0] exp_v;
        logic        exp_fail;
        logic        exp_lock;

        // Sequence 1: auth fail/ok, single vote, ignored vote, bad ballot, A,B,C,D,A tallies.
        vecs.push_back(mk(1'b1, 1'b0, 4'h0,  5'b00000, 1'b0, F_NO,   3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h5,  5'b00000, 1'b0, F_FAIL, 3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00001, 1'b0, F_ACK,  3'd0, 40'h01));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00010, 1'b0, F_NO,   3'd0, 40'h01));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h01));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00110, 1'b0, F_ERR,  3'd0, 40'h01));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00010, 1'b0, F_ACK,  3'd0, 40'h0101));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h0101));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00100, 1'b0, F_ACK,  3'd0, 40'h010101));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h010101));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b01000, 1'b0, F_ACK,  3'd0, 40'h01010101));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h01010101));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00001, 1'b0, F_ACK,  3'd0, 40'h01010102));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h01010102));
        // end_voting beats the pending vote in READY.
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00001, 1'b1, F_NO,   3'd0, 40'h01010102));
        push_idle(5, 40'h01010102);
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00000, 1'b0, F_WV,   3'd0, 40'h01010102));
        vecs.push_back(mk(1'b0, 1'b1, 4'h3,  5'b00000, 1'b0, F_WV,   3'd0, 40'h01010102));
        // Sequence 2: A=2, C=2 tie; end_voting beats a wrong auth in AUTH_WAIT.
        vecs.push_back(mk(1'b1, 1'b0, 4'h0,  5'b00000, 1'b0, F_NO,   3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00001, 1'b0, F_ACK,  3'd0, 40'h01));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h01));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00100, 1'b0, F_ACK,  3'd0, 40'h010001));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h010001));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00001, 1'b0, F_ACK,  3'd0, 40'h010002));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h010002));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00100, 1'b0, F_ACK,  3'd0, 40'h020002));
        vecs.push_back(mk(1'b0, 1'b1, 4'h5,  5'b00000, 1'b1, F_NO,   3'd0, 40'h020002));
        push_idle(5, 40'h020002);
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00000, 1'b0, F_WV | F_TIE, 3'd0, 40'h020002));
        // Sequence 3: all tallies zero.
        vecs.push_back(mk(1'b1, 1'b0, 4'h0,  5'b00000, 1'b0, F_NO,   3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00000, 1'b1, F_NO,   3'd0, 40'h0));
        push_idle(5, 40'h0);
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00000, 1'b0, F_WV | F_TIE, 3'd0, 40'h0));
        // Sequence 4: A=1, B=1 tie, then E=2 takes over and clears the tie.
        vecs.push_back(mk(1'b1, 1'b0, 4'h0,  5'b00000, 1'b0, F_NO,   3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00000, 1'b0, F_NO,   3'd0, 40'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00001, 1'b0, F_ACK,  3'd0, 40'h01));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h01));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00010, 1'b0, F_ACK,  3'd0, 40'h0101));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h0101));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b10000, 1'b0, F_ACK,  3'd0, 40'h0100000101));
        vecs.push_back(mk(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, F_OK,   3'd0, 40'h0100000101));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b10000, 1'b0, F_ACK,  3'd0, 40'h0200000101));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00000, 1'b1, F_NO,   3'd0, 40'h0200000101));
        push_idle(5, 40'h0200000101);
        vecs.push_back(mk(1'b0, 1'b0, 4'h0,  5'b00000, 1'b0, F_WV,   3'd4, 40'h0200000101));

        // Reset state.
        drive(1'b0, 1'b0, 4'h0, 5'b00000, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        step();
        chk("reset_outputs",
            {44'h0, auth_ok, auth_fail, vote_ack, vote_err, locked, winner_valid, tie, winner_idx, vote_counts[9:0]},
            64'h0);
        chk("reset_sat_counts", {54'h0, s_vote_counts}, 64'h0);
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].au, vecs[i].pw, vecs[i].vt, vecs[i].ev, 1'b0);
            step();
            got_v = {auth_ok, auth_fail, vote_ack, vote_err, locked, winner_valid, tie, winner_idx, vote_counts};
            exp_v = {vecs[i].flags, vecs[i].widx, vecs[i].cnt};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d: got %0h expected %0h", i, got_v, exp_v);
            end
        end

        // Saturation: four votes for B; narrow copy saturates at 3.
        drive(1'b1, 1'b0, 4'h0, 5'b00000, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, 1'b0);
            step();
            chk("sat_auth_ok", {63'h0, s_auth_ok}, 64'h1);
            drive(1'b0, 1'b0, 4'h0, 5'b00010, 1'b0, 1'b0);
            step();
            chk("sat_ack", {63'h0, s_vote_ack}, 64'h1);
            chk("sat_b_count", {62'h0, s_vote_counts[3:2]}, (i < 3) ? 64'(i + 1) : 64'd3);
            chk("wide_b_count", {56'h0, vote_counts[15:8]}, 64'(i + 1));
        end

        // Held wrong password: one failure per cycle (lockout on the third when enabled).
        drive(1'b0, 1'b1, 4'h3, 5'b00000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef VOTE_LOCKOUT_EN
            exp_fail = (i < 3);
            exp_lock = (i >= 2);
`else
            exp_fail = 1'b1;
            exp_lock = 1'b0;
`endif
            chk("held_fail", {63'h0, auth_fail}, {63'h0, exp_fail});
            chk("held_lock", {63'h0, locked}, {63'h0, exp_lock});
        end
        drive(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, 1'b0);
        step();
`ifdef VOTE_LOCKOUT_EN
        chk("locked_ignores_auth", {63'h0, auth_ok}, 64'h0);
        drive(1'b0, 1'b0, 4'h0, 5'b00000, 1'b1, 1'b1);
        step();
        chk("admin_clear_unlock", {63'h0, locked}, 64'h0);
        drive(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, 1'b0);
        step();
        chk("auth_after_clear", {63'h0, auth_ok}, 64'h1);
`else
        chk("auth_after_fails", {63'h0, auth_ok}, 64'h1);
`endif
        drive(1'b0, 1'b0, 4'h0, 5'b00001, 1'b0, 1'b0);
        step();
        chk("post_lock_ack", {63'h0, vote_ack}, 64'h1);
        chk("tallies_kept", {24'h0, vote_counts}, 64'h0000000401);

        // Reset in the middle of a scan.
        drive(1'b0, 1'b0, 4'h0, 5'b00000, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'h0, 5'b00000, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midscan_reset_counts", {24'h0, vote_counts}, 64'h0);
        chk("midscan_reset_flags", {60'h0, winner_valid, tie, locked, vote_ack}, 64'h0);
        drive(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, 1'b0);
        step();
        chk("idle_ignores_auth", {63'h0, auth_ok}, 64'h0);
        drive(1'b1, 1'b0, 4'h0, 5'b00000, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, PW_OK, 5'b00000, 1'b0, 1'b0);
        step();
        chk("auth_after_restart", {63'h0, auth_ok}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
